// File: rtl/io_pwr_seq_ctrl.sv
// io_pwr_seq_ctrl: IO-ring power-up sequencer in the always-on core domain.
// Synchronizes and debounces the VSUP/VDDIO level-detector flags, releases pad
// retention, then enables the pad banks one at a time to limit inrush and SSO.
// Optional build macro IO_PWR_SEQ_BROWNOUT_CNT_EN adds an 8-bit saturating
// brownout event counter on port brownout_cnt_o.
module io_pwr_seq_ctrl #(
    parameter int N_BANKS      = 4,
    parameter int DEBOUNCE_CYC = 64,
    parameter int STEP_CYC     = 16,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               vsup_ok_i,
    input  logic               vddio_ok_i,
    output logic               pad_ret_o,
    output logic [N_BANKS-1:0] bank_en_o,
    output logic               ready_o,
    output logic               fault_o,
    output logic [2:0]         state_o
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
    ,
    output logic [7:0]         brownout_cnt_o
`endif
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_WAIT_SUP = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_ENABLE   = 3'd4,
        ST_READY    = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    localparam int CNT_MAX = (DEBOUNCE_CYC > STEP_CYC) ? DEBOUNCE_CYC : STEP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int TO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam int IDX_W   = $clog2(N_BANKS) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_BANKS - 1);

    state_t             r_state;
    state_t             w_stateNext;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cntNext;
    logic [TO_W-1:0]    r_toCnt;
    logic [TO_W-1:0]    w_toCntNext;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idxNext;
    logic [IDX_W-1:0]   w_idxInc;
    logic               r_padRet;
    logic               w_padRetNext;
    logic [N_BANKS-1:0] r_bankEn;
    logic [N_BANKS-1:0] w_bankEnNext;
    logic               r_ready;
    logic               r_fault;
    logic               r_vsupMeta;
    logic               r_vsupSync;
    logic               r_vddioMeta;
    logic               r_vddioSync;
    logic               w_supOk;
    logic               w_supLoss;

    assign w_supOk   = r_vsupSync & r_vddioSync;
    assign w_supLoss = !w_supOk &&
                       ((r_state == ST_RELEASE) || (r_state == ST_ENABLE) || (r_state == ST_READY));
    assign w_idxInc  = r_idx + IDX_W'(1);

    // Two-flop synchronizers for the asynchronous supply-detector flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vsupMeta  <= 1'b0;
            r_vsupSync  <= 1'b0;
            r_vddioMeta <= 1'b0;
            r_vddioSync <= 1'b0;
        end else begin
            r_vsupMeta  <= vsup_ok_i;
            r_vsupSync  <= r_vsupMeta;
            r_vddioMeta <= vddio_ok_i;
            r_vddioSync <= r_vddioMeta;
        end
    end

    // Next-state, counter and next-output logic; brownout and start drop override the normal flow
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_toCntNext  = r_toCnt;
        w_idxNext    = r_idx;
        w_padRetNext = r_padRet;
        w_bankEnNext = r_bankEn;

        case (r_state)
            ST_OFF: begin
                if (start_i) begin
                    w_stateNext = ST_WAIT_SUP;
                    w_toCntNext = '0;
                    w_cntNext   = '0;
                end
            end
            ST_WAIT_SUP: begin
                if (w_supOk) begin
                    w_stateNext = ST_DEBOUNCE;
                    w_cntNext   = '0;
                end else if (r_toCnt == TO_LAST) begin
                    w_stateNext = ST_FAULT;
                    w_toCntNext = '0;
                    w_cntNext   = '0;
                end else begin
                    w_toCntNext = r_toCnt + TO_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!w_supOk) begin
                    w_stateNext = ST_WAIT_SUP;
                    w_cntNext   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_stateNext  = ST_RELEASE;
                    w_cntNext    = '0;
                    w_padRetNext = 1'b0;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (r_cnt == STEP_LAST) begin
                    w_stateNext  = ST_ENABLE;
                    w_cntNext    = '0;
                    w_idxNext    = '0;
                    w_bankEnNext = r_bankEn | N_BANKS'(1);
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            ST_ENABLE: begin
                if (r_idx == IDX_LAST) begin
                    w_stateNext = ST_READY;
                    w_cntNext   = '0;
                end else if (r_cnt == STEP_LAST) begin
                    w_cntNext    = '0;
                    w_idxNext    = w_idxInc;
                    w_bankEnNext = r_bankEn | (N_BANKS'(1) << w_idxInc);
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            ST_READY: begin
                w_stateNext = ST_READY;
            end
            ST_FAULT: begin
                if (!start_i) begin
                    w_stateNext = ST_OFF;
                    w_cntNext   = '0;
                    w_toCntNext = '0;
                end
            end
            default: begin
                w_stateNext = ST_OFF;
            end
        endcase

        if (w_supLoss) begin
            w_stateNext  = ST_WAIT_SUP;
            w_cntNext    = '0;
            w_toCntNext  = '0;
            w_idxNext    = '0;
            w_padRetNext = 1'b1;
            w_bankEnNext = '0;
        end

        if (!start_i && (r_state != ST_FAULT)) begin
            w_stateNext  = ST_OFF;
            w_cntNext    = '0;
            w_toCntNext  = '0;
            w_idxNext    = '0;
            w_padRetNext = 1'b1;
            w_bankEnNext = '0;
        end

        if ((w_stateNext == ST_FAULT) || (w_stateNext == ST_OFF)) begin
            w_padRetNext = 1'b1;
            w_bankEnNext = '0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_OFF;
            r_cnt    <= '0;
            r_toCnt  <= '0;
            r_idx    <= '0;
            r_padRet <= 1'b1;
            r_bankEn <= '0;
            r_ready  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_toCnt  <= w_toCntNext;
            r_idx    <= w_idxNext;
            r_padRet <= w_padRetNext;
            r_bankEn <= w_bankEnNext;
            r_ready  <= (w_stateNext == ST_READY);
            r_fault  <= (w_stateNext == ST_FAULT);
        end
    end

`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
    logic [7:0] r_boCnt;

    // Saturating count of supply losses after retention release; cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_boCnt <= 8'd0;
        end else if (w_supLoss && (r_boCnt != 8'hFF)) begin
            r_boCnt <= r_boCnt + 8'd1;
        end
    end

    assign brownout_cnt_o = r_boCnt;
`endif

    assign pad_ret_o = r_padRet;
    assign bank_en_o = r_bankEn;
    assign ready_o   = r_ready;
    assign fault_o   = r_fault;
    assign state_o   = r_state;

endmodule

// File: tb/tb_io_pwr_seq_ctrl.sv
// tb_io_pwr_seq_ctrl: self-checking bench for io_pwr_seq_ctrl (default parameters).
// Expected output vectors are queued with the cycle they are due and popped when
// that cycle is sampled. Honors IO_PWR_SEQ_BROWNOUT_CNT_EN for the counter port.
module tb_io_pwr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic       vsup_ok_i;
    logic       vddio_ok_i;
    logic       pad_ret_o;
    logic [3:0] bank_en_o;
    logic       ready_o;
    logic       fault_o;
    logic [2:0] state_o;
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
    logic [7:0] brownout_cnt_o;
`endif

    typedef struct {
        int         cyc;
        logic [9:0] v;
    } exp_t;

    exp_t       sbQ[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [9:0] obs;

    assign obs = {pad_ret_o, bank_en_o, ready_o, fault_o, state_o};

    io_pwr_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .vsup_ok_i  (vsup_ok_i),
        .vddio_ok_i (vddio_ok_i),
        .pad_ret_o  (pad_ret_o),
        .bank_en_o  (bank_en_o),
        .ready_o    (ready_o),
        .fault_o    (fault_o),
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
        .brownout_cnt_o (brownout_cnt_o),
`endif
        .state_o    (state_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter so expectations can name the edge they follow
    always @(posedge clk) cyc <= cyc + 1;

    task automatic pushExp(input int c, input logic pr, input logic [3:0] be,
                           input logic rd, input logic ft, input logic [2:0] st);
        exp_t e;
        e.cyc = c;
        e.v   = {pr, be, rd, ft, st};
        sbQ.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; vsup_ok_i = 1'b0; vddio_ok_i = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 10'b1_0000_0_0_000) begin
            bad++; $display("[TB] FAIL reset_values got=%h exp=%h", obs, 10'b1_0000_0_0_000);
        end
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
        total++;
        if (brownout_cnt_o !== 8'd0) begin
            bad++; $display("[TB] FAIL reset_bocnt got=%0d exp=0", brownout_cnt_o);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 10'b1_0000_0_0_000) begin
            bad++; $display("[TB] FAIL idle_off got=%h exp=%h", obs, 10'b1_0000_0_0_000);
        end
    endtask

    task automatic test_nominal();
        int   base;
        exp_t e;
        base = cyc;
        pushExp(base + 1,   1, 4'h0, 0, 0, 3'd1);
        pushExp(base + 5,   1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 68,  1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 69,  0, 4'h0, 0, 0, 3'd3);
        pushExp(base + 84,  0, 4'h0, 0, 0, 3'd3);
        pushExp(base + 85,  0, 4'h1, 0, 0, 3'd4);
        pushExp(base + 101, 0, 4'h3, 0, 0, 3'd4);
        pushExp(base + 117, 0, 4'h7, 0, 0, 3'd4);
        pushExp(base + 133, 0, 4'hF, 0, 0, 3'd4);
        pushExp(base + 134, 0, 4'hF, 1, 0, 3'd5);
        start_i = 1'b1;
        for (int k = 1; k <= 136; k++) begin
            @(negedge clk);
            if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
                e = sbQ.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++; $display("[TB] FAIL nominal cyc=%0d got=%h exp=%h", cyc - base, obs, e.v);
                end
            end
            if (k == 2) begin vsup_ok_i = 1'b1; vddio_ok_i = 1'b1; end
        end
        total++;
        if (sbQ.size() != 0) begin
            bad++; $display("[TB] FAIL nominal_pending got=%0d exp=0", sbQ.size()); sbQ.delete();
        end
    endtask

    task automatic test_brownout();
        int   base;
        exp_t e;
        base = cyc;
        pushExp(base + 2, 0, 4'hF, 1, 0, 3'd5);
        pushExp(base + 3, 1, 4'h0, 0, 0, 3'd1);
        pushExp(base + 5, 1, 4'h0, 0, 0, 3'd1);
        pushExp(base + 6, 1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 7, 1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 8, 1, 4'h0, 0, 0, 3'd0);
        vddio_ok_i = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
                e = sbQ.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++; $display("[TB] FAIL brownout cyc=%0d got=%h exp=%h", cyc - base, obs, e.v);
                end
            end
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
            if (k == 2 || k == 3) begin
                total++;
                if (brownout_cnt_o !== 8'(k - 2)) begin
                    bad++; $display("[TB] FAIL brownout_cnt k=%0d got=%0d exp=%0d", k, brownout_cnt_o, k - 2);
                end
            end
`endif
            if (k == 3) vddio_ok_i = 1'b1;
            if (k == 7) start_i = 1'b0;
        end
        total++;
        if (sbQ.size() != 0) begin
            bad++; $display("[TB] FAIL brownout_pending got=%0d exp=0", sbQ.size()); sbQ.delete();
        end
    endtask

    task automatic test_glitch();
        int   base;
        exp_t e;
        base = cyc;
        pushExp(base + 2,   1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 44,  1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 45,  1, 4'h0, 0, 0, 3'd1);
        pushExp(base + 46,  1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 66,  1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 109, 1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 110, 0, 4'h0, 0, 0, 3'd3);
        pushExp(base + 111, 0, 4'h0, 0, 0, 3'd3);
        pushExp(base + 112, 1, 4'h0, 0, 0, 3'd0);
        start_i = 1'b1;
        for (int k = 1; k <= 113; k++) begin
            @(negedge clk);
            if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
                e = sbQ.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++; $display("[TB] FAIL glitch cyc=%0d got=%h exp=%h", cyc - base, obs, e.v);
                end
            end
            if (k == 42) vsup_ok_i = 1'b0;
            if (k == 43) vsup_ok_i = 1'b1;
            if (k == 111) start_i = 1'b0;
        end
        total++;
        if (sbQ.size() != 0) begin
            bad++; $display("[TB] FAIL glitch_pending got=%0d exp=0", sbQ.size()); sbQ.delete();
        end
    endtask

    task automatic test_start_drop();
        int   base;
        exp_t e;
        base = cyc;
        pushExp(base + 1,  1, 4'h0, 0, 0, 3'd1);
        pushExp(base + 2,  1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 10, 1, 4'h0, 0, 0, 3'd2);
        pushExp(base + 11, 1, 4'h0, 0, 0, 3'd0);
        start_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
                e = sbQ.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++; $display("[TB] FAIL start_drop cyc=%0d got=%h exp=%h", cyc - base, obs, e.v);
                end
            end
            if (k == 10) start_i = 1'b0;
        end
        total++;
        if (sbQ.size() != 0) begin
            bad++; $display("[TB] FAIL start_drop_pending got=%0d exp=0", sbQ.size()); sbQ.delete();
        end
    endtask

    task automatic test_reset_mid();
        int   base;
        exp_t e;
        base = cyc;
        pushExp(base + 66,  0, 4'h0, 0, 0, 3'd3);
        pushExp(base + 82,  0, 4'h1, 0, 0, 3'd4);
        pushExp(base + 98,  0, 4'h3, 0, 0, 3'd4);
        pushExp(base + 100, 0, 4'h3, 0, 0, 3'd4);
        pushExp(base + 101, 1, 4'h0, 0, 0, 3'd0);
        pushExp(base + 102, 1, 4'h0, 0, 0, 3'd1);
        pushExp(base + 103, 1, 4'h0, 0, 0, 3'd0);
        start_i = 1'b1;
        for (int k = 1; k <= 104; k++) begin
            @(negedge clk);
            if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
                e = sbQ.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++; $display("[TB] FAIL reset_mid cyc=%0d got=%h exp=%h", cyc - base, obs, e.v);
                end
            end
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
            if (k == 101) begin
                total++;
                if (brownout_cnt_o !== 8'd0) begin
                    bad++; $display("[TB] FAIL reset_mid_bocnt got=%0d exp=0", brownout_cnt_o);
                end
            end
`endif
            if (k == 100) rst_n = 1'b0;
            if (k == 101) rst_n = 1'b1;
            if (k == 102) start_i = 1'b0;
        end
        total++;
        if (sbQ.size() != 0) begin
            bad++; $display("[TB] FAIL reset_mid_pending got=%0d exp=0", sbQ.size()); sbQ.delete();
        end
    endtask

    task automatic test_timeout();
        int   base;
        exp_t e;
        base = cyc;
        pushExp(base + 4,    1, 4'h0, 0, 0, 3'd1);
        pushExp(base + 4099, 1, 4'h0, 0, 0, 3'd1);
        pushExp(base + 4100, 1, 4'h0, 0, 1, 3'd6);
        pushExp(base + 4110, 1, 4'h0, 0, 1, 3'd6);
        pushExp(base + 4113, 1, 4'h0, 0, 0, 3'd0);
        vsup_ok_i  = 1'b0;
        vddio_ok_i = 1'b0;
        for (int k = 1; k <= 4114; k++) begin
            @(negedge clk);
            if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
                e = sbQ.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++; $display("[TB] FAIL timeout cyc=%0d got=%h exp=%h", cyc - base, obs, e.v);
                end
            end
            if (k == 3) start_i = 1'b1;
            if (k == 4102) begin vsup_ok_i = 1'b1; vddio_ok_i = 1'b1; end
            if (k == 4112) start_i = 1'b0;
        end
        total++;
        if (sbQ.size() != 0) begin
            bad++; $display("[TB] FAIL timeout_pending got=%0d exp=0", sbQ.size()); sbQ.delete();
        end
    endtask

`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
    task automatic test_brownout_sat();
        int expCnt;
        expCnt     = 0;
        vsup_ok_i  = 1'b1;
        vddio_ok_i = 1'b0;
        start_i    = 1'b1;
        repeat (4) @(negedge clk);
        for (int n = 1; n <= 300; n++) begin
            vddio_ok_i = 1'b1;
            repeat (70) @(negedge clk);
            vddio_ok_i = 1'b0;
            repeat (4) @(negedge clk);
            expCnt = (expCnt < 255) ? expCnt + 1 : 255;
            if (n == 100 || n == 255 || n == 300) begin
                total++;
                if (brownout_cnt_o !== 8'(expCnt)) begin
                    bad++; $display("[TB] FAIL bocnt_sat n=%0d got=%0d exp=%0d", n, brownout_cnt_o, expCnt);
                end
            end
        end
        start_i = 1'b0;
        @(negedge clk);
    endtask
`endif

    // Scenario sequence
    initial begin
        test_reset();
        test_nominal();
        test_brownout();
        test_glitch();
        test_start_drop();
        test_reset_mid();
        test_timeout();
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
        test_brownout_sat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
